circle_stream_monitor: RTL and testbench

Downstream consumer of the 4-stage circular DFF link. Takes each sample the link emits under its write strobe and checks that the stream is a continuous modulo-2^WIDTH count, as produced by the upstream 8-bit counter. It also maintains a 4-sample window sum and average, and raises error and alarm status. Its status outputs drive the system's data-path health indication.

---
 rtl/circle_stream_monitor.sv | 168 ++++++++++++++++
 tb/tb_circle_stream_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circle_stream_monitor.sv
// Continuity monitor for the circular DFF link: checks a mod-2^WIDTH count stream,
// keeps a 4-sample window sum/average and error/alarm status. Min/max: CIRCLE_MONITOR_MINMAX_EN.
module circle_stream_monitor #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr,
  output logic [WIDTH+1:0] sum,
  output logic [WIDTH-1:0] avg,
  output logic             avg_valid,
  output logic             seq_err,
  output logic [7:0]       err_cnt,
  output logic             locked,
  output logic             alarm,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val
);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StTrack
  } state_e;

  state_e                  r_state, w_state_next;
  logic [3:0][WIDTH-1:0]   r_win, w_win_next;
  logic [WIDTH-1:0]        r_last, w_last_next;
  logic [2:0]              r_fill, w_fill_next;
  logic [WIDTH+1:0]        r_sum, w_sum_next;
  logic                    r_avg_valid, w_avg_valid_next;
  logic                    r_seq_err, w_seq_err_next;
  logic [7:0]              r_err_cnt, w_err_next;
  logic                    r_alarm, w_alarm_next;

  logic [WIDTH-1:0]        w_last_inc;
  logic                    w_cont;
  logic [WIDTH+1:0]        w_win_sum;

  assign w_last_inc = r_last + 1'b1;
  assign w_cont     = (in_data == w_last_inc);
  // Sum of the window as it will look once in_data is shifted in.
  assign w_win_sum  = {2'b00, in_data} + {2'b00, r_win[0]} + {2'b00, r_win[1]}
                    + {2'b00, r_win[2]};

  always_comb begin
    w_state_next     = r_state;
    w_win_next       = r_win;
    w_last_next      = r_last;
    w_fill_next      = r_fill;
    w_sum_next       = r_sum;
    w_avg_valid_next = 1'b0;
    w_seq_err_next   = 1'b0;
    w_err_next       = r_err_cnt;
    w_alarm_next     = r_alarm;

    if (clr) begin
      w_state_next = StIdle;
      w_win_next   = '0;
      w_last_next  = '0;
      w_fill_next  = '0;
      w_sum_next   = '0;
      w_err_next   = '0;
      w_alarm_next = 1'b0;
    end else if (in_valid) begin
      w_last_next = in_data;
      unique case (r_state)
        StIdle: begin
          w_win_next    = '0;
          w_win_next[0] = in_data;
          w_fill_next   = 3'd1;
          w_state_next  = StFill;
        end
        StFill, StTrack: begin
          if (w_cont) begin
            w_win_next = {r_win[2:0], in_data};
            if (r_state == StTrack || r_fill == 3'd3) begin
              w_fill_next      = 3'd4;
              w_sum_next       = w_win_sum;
              w_avg_valid_next = 1'b1;
              w_state_next     = StTrack;
            end else begin
              w_fill_next = r_fill + 3'd1;
            end
          end else begin
            w_seq_err_next = 1'b1;
            w_err_next     = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
            w_win_next     = '0;
            w_win_next[0]  = in_data;
            w_fill_next    = 3'd1;
            w_state_next   = StFill;
          end
        end
        default: w_state_next = StIdle;
      endcase
      w_alarm_next = r_alarm | (w_err_next >= 8'(ERR_LIMIT));
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state     <= StIdle;
      r_win       <= '0;
      r_last      <= '0;
      r_fill      <= '0;
      r_sum       <= '0;
      r_avg_valid <= 1'b0;
      r_seq_err   <= 1'b0;
      r_err_cnt   <= '0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_win       <= w_win_next;
      r_last      <= w_last_next;
      r_fill      <= w_fill_next;
      r_sum       <= w_sum_next;
      r_avg_valid <= w_avg_valid_next;
      r_seq_err   <= w_seq_err_next;
      r_err_cnt   <= w_err_next;
      r_alarm     <= w_alarm_next;
    end
  end

  assign sum       = r_sum;
  assign avg       = r_sum[WIDTH+1:2];
  assign avg_valid = r_avg_valid;
  assign seq_err   = r_seq_err;
  assign err_cnt   = r_err_cnt;
  assign locked    = (r_state == StTrack);
  assign alarm     = r_alarm;

`ifdef CIRCLE_MONITOR_MINMAX_EN
  logic [WIDTH-1:0] r_min, w_min_next;
  logic [WIDTH-1:0] r_max, w_max_next;

  always_comb begin
    w_min_next = r_min;
    w_max_next = r_max;
    if (clr) begin
      w_min_next = '1;
      w_max_next = '0;
    end else if (in_valid) begin
      if (in_data < r_min) w_min_next = in_data;
      if (in_data > r_max) w_max_next = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_min <= '1;
      r_max <= '0;
    end else begin
      r_min <= w_min_next;
      r_max <= w_max_next;
    end
  end

  assign min_val = r_min;
  assign max_val = r_max;
`else
  assign min_val = '1;
  assign max_val = '0;
`endif

endmodule

// File: tb/tb_circle_stream_monitor.sv
// Self-checking bench for circle_stream_monitor: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_circle_stream_monitor;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       clr = 1'b0;
  logic [9:0] sum;
  logic [7:0] avg;
  logic       avg_valid;
  logic       seq_err;
  logic [7:0] err_cnt;
  logic       locked;
  logic       alarm;
  logic [7:0] min_val;
  logic [7:0] max_val;

  int n_cmp = 0;
  int n_fail = 0;

  circle_stream_monitor #(.WIDTH(8), .ERR_LIMIT(3)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .clr      (clr),
    .sum      (sum),
    .avg      (avg),
    .avg_valid(avg_valid),
    .seq_err  (seq_err),
    .err_cnt  (err_cnt),
    .locked   (locked),
    .alarm    (alarm),
    .min_val  (min_val),
    .max_val  (max_val)
  );

  always #5 clk = ~clk;

  // Reference model: the window is the run of consecutive samples since the last break.
  int mq[$];
  int m_last, m_sum, m_err, m_min, m_max;
  bit m_alarm, m_av, m_se;

  function automatic void model_reset();
    mq.delete();
    m_last = 0; m_sum = 0; m_err = 0; m_alarm = 0;
    m_av = 0; m_se = 0; m_min = 255; m_max = 0;
  endfunction

  function automatic void model_update(input bit rst, input bit v, input bit c, input int d);
    m_av = 0;
    m_se = 0;
    if (!rst || c) begin
      model_reset();
    end else if (v) begin
      if (mq.size() == 0) begin
        mq.push_back(d);
      end else if (d == (m_last + 1) % 256) begin
        mq.push_back(d);
        if (mq.size() > 4) void'(mq.pop_front());
        if (mq.size() == 4) begin
          m_sum = mq[0] + mq[1] + mq[2] + mq[3];
          m_av = 1;
        end
      end else begin
        m_se = 1;
        if (m_err < 255) m_err++;
        if (m_err >= 3) m_alarm = 1;
        mq.delete();
        mq.push_back(d);
      end
      m_last = d;
      if (d < m_min) m_min = d;
      if (d > m_max) m_max = d;
    end
  endfunction

  task automatic step(input bit rst, input bit v, input bit c, input logic [7:0] d);
    Reset = rst; in_valid = v; clr = c; in_data = d;
    @(posedge clk);
    #1;
    model_update(rst, v, c, int'(d));
    in_valid = 1'b0;
    clr = 1'b0;
    Reset = 1'b1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    logic [7:0] exp_min;
    exp_min = 8'hFF;
    do_reset();
    n_cmp++;
    if ({sum, avg, avg_valid, seq_err, err_cnt, locked, alarm} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: sum=%0d avg=%0d av=%0b se=%0b err=%0d lk=%0b al=%0b want 0",
               sum, avg, avg_valid, seq_err, err_cnt, locked, alarm);
    end
    n_cmp++;
    if (min_val !== exp_min || max_val !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_minmax: min=%h max=%h want ff 00", min_val, max_val);
    end
  endtask

  task automatic test_continuity();
    logic [7:0] exp_min, exp_max;
    do_reset();
    for (int i = 5; i <= 7; i++) step(1'b1, 1'b1, 1'b0, 8'(i));
    n_cmp++;
    if (avg_valid !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_fill3: av=%0b lk=%0b want 0 0", avg_valid, locked);
    end
    step(1'b1, 1'b1, 1'b0, 8'h08);
    n_cmp++;
    if (avg_valid !== 1'b1 || sum !== 10'd26 || avg !== 8'd6 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_first: av=%0b sum=%0d avg=%0d lk=%0b want 1 26 6 1",
               avg_valid, sum, avg, locked);
    end
    step(1'b1, 1'b1, 1'b0, 8'h09);
    n_cmp++;
    if (avg_valid !== 1'b1 || sum !== 10'd30 || avg !== 8'd7) begin
      n_fail++;
      $display("FAIL cont_next: av=%0b sum=%0d avg=%0d want 1 30 7", avg_valid, sum, avg);
    end
`ifdef CIRCLE_MONITOR_MINMAX_EN
    exp_min = 8'h05; exp_max = 8'h09;
`else
    exp_min = 8'hFF; exp_max = 8'h00;
`endif
    n_cmp++;
    if (min_val !== exp_min || max_val !== exp_max) begin
      n_fail++;
      $display("FAIL minmax: min=%h max=%h want %h %h", min_val, max_val, exp_min, exp_max);
    end
  endtask

  // Continues from the TRACK state left by test_continuity.
  task automatic test_break();
    step(1'b1, 1'b1, 1'b0, 8'h20);
    n_cmp++;
    if (seq_err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || avg_valid !== 1'b0
        || sum !== 10'd30) begin
      n_fail++;
      $display("FAIL break_pulse: se=%0b err=%0d lk=%0b av=%0b sum=%0d want 1 1 0 0 30",
               seq_err, err_cnt, locked, avg_valid, sum);
    end
    step(1'b1, 1'b1, 1'b0, 8'h21);
    n_cmp++;
    if (seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL break_pulse_width: se=%0b want 0", seq_err);
    end
    step(1'b1, 1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b1, 1'b0, 8'h23);
    n_cmp++;
    if (avg_valid !== 1'b1 || sum !== 10'd134 || avg !== 8'd33 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL break_refill: av=%0b sum=%0d avg=%0d lk=%0b want 1 134 33 1",
               avg_valid, sum, avg, locked);
    end
  endtask

  task automatic test_wrap();
    int se_seen;
    se_seen = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'hFE);
    step(1'b1, 1'b1, 1'b0, 8'hFF);
    se_seen += int'(seq_err);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    se_seen += int'(seq_err);
    step(1'b1, 1'b1, 1'b0, 8'h01);
    se_seen += int'(seq_err);
    n_cmp++;
    if (se_seen != 0 || avg_valid !== 1'b1 || sum !== 10'd510 || avg !== 8'd127) begin
      n_fail++;
      $display("FAIL wrap: se_count=%0d av=%0b sum=%0d avg=%0d want 0 1 510 127",
               se_seen, avg_valid, sum, avg);
    end
  endtask

  task automatic test_alarm_clr();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h10);
    step(1'b1, 1'b1, 1'b0, 8'h50);
    step(1'b1, 1'b1, 1'b0, 8'h70);
    n_cmp++;
    if (alarm !== 1'b0 || err_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL alarm_early: al=%0b err=%0d want 0 2", alarm, err_cnt);
    end
    step(1'b1, 1'b1, 1'b0, 8'h90);
    n_cmp++;
    if (alarm !== 1'b1 || err_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL alarm_set: al=%0b err=%0d want 1 3", alarm, err_cnt);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h91 + i));
    n_cmp++;
    if (alarm !== 1'b1 || locked !== 1'b1 || err_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL alarm_sticky: al=%0b lk=%0b err=%0d want 1 1 3", alarm, locked, err_cnt);
    end
    // clr collides with a valid sample: the sample must be dropped.
    step(1'b1, 1'b1, 1'b1, 8'h95);
    n_cmp++;
    if ({sum, avg, avg_valid, seq_err, err_cnt, locked, alarm} !== 31'd0) begin
      n_fail++;
      $display("FAIL clr_collide: sum=%0d avg=%0d av=%0b se=%0b err=%0d lk=%0b al=%0b want 0",
               sum, avg, avg_valid, seq_err, err_cnt, locked, alarm);
    end
    step(1'b1, 1'b1, 1'b0, 8'h42);
    n_cmp++;
    if (seq_err !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_idle: se=%0b lk=%0b want 0 0", seq_err, locked);
    end
  endtask

  task automatic test_reset_midfill();
    int av_seen;
    av_seen = 0;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h30);
    step(1'b1, 1'b1, 1'b0, 8'h31);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(8'h32 + i));
      av_seen += int'(avg_valid);
    end
    step(1'b1, 1'b1, 1'b0, 8'h35);
    n_cmp++;
    if (av_seen != 0 || avg_valid !== 1'b1 || sum !== 10'd206) begin
      n_fail++;
      $display("FAIL reset_midfill: early_av=%0d av=%0b sum=%0d want 0 1 206",
               av_seen, avg_valid, sum);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 1'b0, 8'((3 * i) % 256));
    n_cmp++;
    if (err_cnt !== 8'd255 || alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL err_saturate: err=%0d al=%0b want 255 1", err_cnt, alarm);
    end
  endtask

  task automatic test_random();
    logic [7:0] d, exp_min, exp_max;
    bit v, c, r;
    int nxt;
    do_reset();
    model_reset();
    nxt = int'($urandom_range(0, 255));
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 99) < 2);
      r = ($urandom_range(0, 199) != 0);
      d = ($urandom_range(0, 9) < 8) ? 8'(nxt) : 8'($urandom_range(0, 255));
      step(r, v, c, d);
      nxt = (m_last + 1) % 256;
`ifdef CIRCLE_MONITOR_MINMAX_EN
      exp_min = 8'(m_min); exp_max = 8'(m_max);
`else
      exp_min = 8'hFF; exp_max = 8'h00;
`endif
      n_cmp++;
      if (sum !== 10'(m_sum) || avg !== 8'(m_sum / 4)) begin
        n_fail++;
        $display("FAIL rnd_sum[%0d]: sum=%0d avg=%0d want %0d %0d", i, sum, avg, m_sum,
                 m_sum / 4);
      end
      n_cmp++;
      if (avg_valid !== m_av || seq_err !== m_se || locked !== (mq.size() == 4)) begin
        n_fail++;
        $display("FAIL rnd_flags[%0d]: av=%0b se=%0b lk=%0b want %0b %0b %0b", i, avg_valid,
                 seq_err, locked, m_av, m_se, mq.size() == 4);
      end
      n_cmp++;
      if (err_cnt !== 8'(m_err) || alarm !== m_alarm) begin
        n_fail++;
        $display("FAIL rnd_err[%0d]: err=%0d al=%0b want %0d %0b", i, err_cnt, alarm, m_err,
                 m_alarm);
      end
      n_cmp++;
      if (min_val !== exp_min || max_val !== exp_max) begin
        n_fail++;
        $display("FAIL rnd_minmax[%0d]: min=%h max=%h want %h %h", i, min_val, max_val,
                 exp_min, exp_max);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_continuity();
    test_break();
    test_wrap();
    test_alarm_clr();
    test_reset_midfill();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
